clint_mh: RTL and testbench

CLINT_MH -- requirements
Module: clint_mh

---
 rtl/clint_mh.sv | 168 ++++++++++++++++
 tb/tb_clint_mh.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_mh.sv
// clint_mh: RISC-V core-local interruptor with mtime, per-hart mtimecmp and msip.
// Ports: clk/rst, always-ready req_* bus, rsp_* one cycle later, tick_en, mtip/msip out.
module clint_mh #(
  parameter int NHART    = 1,
  parameter int XLEN     = 64,
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  input  logic              tick_en,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip
);

  localparam logic [15:0] DIV_MAX = 16'(TICK_DIV - 1);

  // mtime sits at byte offset 0xBFF8, i.e. 64-bit word 0x17FF
  localparam logic [28:0] TIME_WORD = 29'h17FF;

  // architectural state
  logic [15:0]      pre_cnt;
  logic [63:0]      mtime;
  logic [63:0]      mtimecmp [NHART];
  logic [NHART-1:0] msip_q;

  // request decode
  logic [31:0]      a;
  logic             hi_half;
  logic             rgn_msip;
  logic             rgn_cmp;
  logic             sel_time;
  logic [10:0]      idx;
  logic             wr;
  logic             tick;
  logic             unused_ok;

  // request data normalised to a 64-bit register view
  logic [63:0]      wd64;
  logic [7:0]       be64;

  // per-hart selects
  logic [NHART-1:0] sel_cmp;
  logic [NHART-1:0] sel_sip;
  logic [NHART-1:0] sip_wr;
  logic [NHART-1:0] sip_val;

  // read path
  logic [63:0]      rd64;
  logic [XLEN-1:0]  rdata;

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] d,
    input logic [7:0]  be
  );
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = d[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign a         = 32'(req_addr);
  assign unused_ok = ^a[1:0];

  // On a 32-bit bus, offset bit 2 picks the upper half of a 64-bit register
  assign hi_half  = (XLEN == 32) && a[2];
  assign idx      = a[13:3];
  assign rgn_msip = (a[31:14] == 18'd0);
  assign rgn_cmp  = (a[31:14] == 18'd1);
  assign sel_time = (a[31:3] == TIME_WORD);

  assign wr   = req_valid && req_we;
  assign tick = tick_en && (pre_cnt == DIV_MAX);

  always_comb begin
    wd64 = 64'(req_wdata);
    be64 = 8'(req_wstrb);
    if (hi_half) begin
      wd64 = wd64 << 32;
      be64 = be64 << 4;
    end
  end

  // Each 64-bit word of the msip region holds two harts:
  // the even hart in lane [31:0], the odd hart in lane [63:32].
  always_comb begin
    sel_cmp = '0;
    sel_sip = '0;
    sip_wr  = '0;
    sip_val = '0;
    for (int h = 0; h < NHART; h++) begin
      sel_cmp[h] = rgn_cmp && (idx == 11'(h));
      sel_sip[h] = rgn_msip && (idx == 11'(h / 2));
      sip_wr[h]  = wr && sel_sip[h] && be64[4*(h%2)];
      sip_val[h] = wd64[32*(h%2)];
    end
  end

  always_comb begin
    rd64 = '0;
    for (int h = 0; h < NHART; h++) begin
      if (sel_cmp[h]) begin
        rd64 = mtimecmp[h];
      end
      if (sel_sip[h]) begin
        rd64[32*(h%2)] = msip_q[h];
      end
    end
    if (sel_time) begin
      rd64 = mtime;
    end
  end

  assign rdata = hi_half ? XLEN'(rd64 >> 32) : XLEN'(rd64);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      mtime     <= '0;
      msip_q    <= '0;
      mtip      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      for (int h = 0; h < NHART; h++) begin
        mtimecmp[h] <= '1;
      end
    end else begin
      if (tick_en) begin
        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      end

      // a bus write to mtime swallows that cycle's tick entirely
      if (wr && sel_time) begin
        mtime <= merge(mtime, wd64, be64);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      for (int h = 0; h < NHART; h++) begin
        if (wr && sel_cmp[h]) begin
          mtimecmp[h] <= merge(mtimecmp[h], wd64, be64);
        end
        if (sip_wr[h]) begin
          msip_q[h] <= sip_val[h];
        end
        mtip[h] <= (mtime >= mtimecmp[h]);
      end

      rsp_valid <= req_valid;
      rsp_rdata <= (req_valid && !req_we) ? rdata : '0;
    end
  end

  assign msip = msip_q;

endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh: checks clint_mh in a 64-bit/3-hart/div-4 build and a 32-bit/2-hart/div-1 build.
// Ports: none; drives both instances and prints one summary line.
module tb_clint_mh;

  localparam int NH = 3;
  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // 64-bit instance
  logic        r64, v64, we64, te64;
  logic [15:0] ad64;
  logic [63:0] wd64;
  logic [7:0]  ws64;
  logic        rv64;
  logic [63:0] rd64;
  logic [2:0]  tip64, sip64;

  // 32-bit instance
  logic        r32, v32, we32, te32;
  logic [15:0] ad32;
  logic [31:0] wd32;
  logic [3:0]  ws32;
  logic        rv32;
  logic [31:0] rd32;
  logic [1:0]  tip32, sip32;

  clint_mh #(.NHART(3), .XLEN(64), .TICK_DIV(4), .ADDR_W(16)) u64 (
    .clk(clk), .rst(r64), .req_valid(v64), .req_we(we64),
    .req_addr(ad64), .req_wdata(wd64), .req_wstrb(ws64), .tick_en(te64),
    .rsp_valid(rv64), .rsp_rdata(rd64), .mtip(tip64), .msip(sip64)
  );

  clint_mh #(.NHART(2), .XLEN(32), .TICK_DIV(1), .ADDR_W(16)) u32 (
    .clk(clk), .rst(r32), .req_valid(v32), .req_we(we32),
    .req_addr(ad32), .req_wdata(wd32), .req_wstrb(ws32), .tick_en(te32),
    .rsp_valid(rv32), .rsp_rdata(rd32), .mtip(tip32), .msip(sip32)
  );

  // observed and expected values of the last 64-bit step
  logic        o_rv, e_rv;
  logic [63:0] o_rd, e_rd;
  logic [2:0]  o_tip, e_tip, o_sip, e_sip;

  // observed values of the last 32-bit step
  logic        q_rv;
  logic [31:0] q_rd;
  logic [1:0]  q_tip, q_sip;

  // reference model of the 64-bit instance
  logic [63:0]    m_time;
  logic [63:0]    m_cmp [NH];
  logic [NH-1:0]  m_sip;
  int unsigned    m_pc;

  function automatic logic [63:0] bmerge(input logic [63:0] old,
                                         input logic [63:0] d,
                                         input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_read(input int unsigned off);
    logic [63:0] r;
    int unsigned k;
    r = '0;
    if (off < 32'h4000) begin
      k = off / 8;
      if (2*k < NH) r[0] = m_sip[2*k];
      if (2*k+1 < NH) r[32] = m_sip[2*k+1];
    end else if (off < 32'h4000 + 8*NH) begin
      r = m_cmp[(off - 32'h4000) / 8];
    end else if (off == 32'hBFF8) begin
      r = m_time;
    end
    return r;
  endfunction

  task automatic m_step(input bit rs, input bit v, input bit we,
                        input logic [15:0] ad, input logic [63:0] wd,
                        input logic [7:0] ws, input bit te);
    int unsigned off;
    int unsigned k;
    bit tk;
    off = {16'b0, ad} & 32'hFFF8;
    if (rs) begin
      m_time = '0;
      m_pc = 0;
      m_sip = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      e_rv = 0; e_rd = '0; e_tip = '0; e_sip = '0;
    end else begin
      e_rv = v;
      e_rd = (v && !we) ? m_read(off) : 64'd0;
      for (int h = 0; h < NH; h++) e_tip[h] = (m_time >= m_cmp[h]);
      tk = te && ((m_pc % TD) == TD - 1);
      if (te) m_pc++;
      if (v && we && off == 32'hBFF8) m_time = bmerge(m_time, wd, ws);
      else if (tk) m_time = m_time + 1;
      if (v && we && off >= 32'h4000 && off < 32'h4000 + 8*NH) begin
        k = (off - 32'h4000) / 8;
        m_cmp[k] = bmerge(m_cmp[k], wd, ws);
      end
      if (v && we && off < 32'h4000) begin
        k = off / 8;
        if (2*k < NH && ws[0]) m_sip[2*k] = wd[0];
        if (2*k+1 < NH && ws[4]) m_sip[2*k+1] = wd[32];
      end
      e_sip = m_sip;
    end
  endtask

  task automatic step64(input bit rs, input bit v, input bit we,
                        input logic [15:0] ad, input logic [63:0] wd,
                        input logic [7:0] ws, input bit te);
    r64 = rs; v64 = v; we64 = we; ad64 = ad;
    wd64 = wd; ws64 = ws; te64 = te;
    m_step(rs, v, we, ad, wd, ws, te);
    @(posedge clk);
    #1;
    o_rv = rv64; o_rd = rd64; o_tip = tip64; o_sip = sip64;
    r64 = 0; v64 = 0; we64 = 0; te64 = 0;
  endtask

  task automatic step32(input bit rs, input bit v, input bit we,
                        input logic [15:0] ad, input logic [31:0] wd,
                        input logic [3:0] ws, input bit te);
    r32 = rs; v32 = v; we32 = we; ad32 = ad;
    wd32 = wd; ws32 = ws; te32 = te;
    @(posedge clk);
    #1;
    q_rv = rv32; q_rd = rd32; q_tip = tip32; q_sip = sip32;
    r32 = 0; v32 = 0; we32 = 0; te32 = 0;
  endtask

  task automatic test_reset;
    step64(1, 1, 1, 16'hBFF8, 64'h1234, 8'hFF, 1);
    step64(1, 1, 0, 16'hBFF8, 64'h0, 8'h00, 1);
    total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", o_rv); end
    total++; if (o_rd !== 64'd0) begin bad++; $display("FAIL reset_rd got=%h exp=0", o_rd); end
    total++; if (o_tip !== 3'b000 || o_sip !== 3'b000) begin bad++; $display("FAIL reset_irq got=%b/%b exp=000/000", o_tip, o_sip); end
    step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL reset_norsp got=%b exp=0", o_rv); end
    step64(0, 1, 0, 16'hBFF8, 64'h0, 8'h0, 0);
    total++; if (o_rv !== 1'b1 || o_rd !== 64'd0) begin bad++; $display("FAIL reset_mtime got=%b/%h exp=1/0", o_rv, o_rd); end
    step64(0, 1, 0, 16'h4010, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL reset_cmp got=%h exp=all-ones", o_rd); end
  endtask

  task automatic test_prescale;
    step64(1, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    for (int i = 0; i < 40; i++) step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 1);
    step64(0, 1, 0, 16'hBFF8, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'd10) begin bad++; $display("FAIL prescale_40 got=%0d exp=10", o_rd); end
    for (int i = 0; i < 8; i++) step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    step64(0, 1, 0, 16'hBFF8, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'd10) begin bad++; $display("FAIL prescale_hold got=%0d exp=10", o_rd); end
    for (int i = 0; i < 2; i++) step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 1);
    for (int i = 0; i < 3; i++) step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    for (int i = 0; i < 2; i++) step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 1);
    step64(0, 1, 0, 16'hBFF8, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'd11) begin bad++; $display("FAIL prescale_resume got=%0d exp=11", o_rd); end
  endtask

  task automatic test_strobe;
    step64(1, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    step64(0, 1, 1, 16'h4000, 64'hFF, 8'h01, 0);
    total++; if (o_rv !== 1'b1 || o_rd !== 64'd0) begin bad++; $display("FAIL strobe_wrsp got=%b/%h exp=1/0", o_rv, o_rd); end
    step64(0, 1, 0, 16'h4000, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL strobe_b0 got=%h exp=ffffffffffffffff", o_rd); end
    step64(0, 1, 1, 16'h4000, 64'h0, 8'h0F, 0);
    step64(0, 1, 0, 16'h4000, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL strobe_lo got=%h exp=ffffffff00000000", o_rd); end
  endtask

  task automatic test_msip;
    step64(1, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    step64(0, 1, 1, 16'h0008, 64'h1_0000_0000, 8'hFF, 0);
    total++; if (o_sip !== 3'b000) begin bad++; $display("FAIL msip_oor got=%b exp=000", o_sip); end
    step64(0, 1, 1, 16'h0000, 64'h1_0000_0001, 8'hFF, 0);
    total++; if (o_sip !== 3'b011) begin bad++; $display("FAIL msip_pair got=%b exp=011", o_sip); end
    step64(0, 1, 0, 16'h0008, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'd0) begin bad++; $display("FAIL msip_rd8 got=%h exp=0", o_rd); end
    step64(0, 1, 0, 16'h0000, 64'h0, 8'h0, 0);
    total++; if (o_rd !== 64'h1_0000_0001) begin bad++; $display("FAIL msip_rd0 got=%h exp=100000001", o_rd); end
    step64(0, 1, 0, 16'h8000, 64'h0, 8'h0, 0);
    total++; if (o_rv !== 1'b1 || o_rd !== 64'd0) begin bad++; $display("FAIL unmapped_rd got=%b/%h exp=1/0", o_rv, o_rd); end
    step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL rsp_once got=%b exp=0", o_rv); end
  endtask

  task automatic test_mtip;
    step64(1, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    step64(0, 1, 1, 16'h4008, 64'd3, 8'hFF, 0);
    for (int i = 0; i < 20; i++) begin
      step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 1);
      total++; if (o_tip !== e_tip) begin bad++; $display("FAIL mtip_run got=%b exp=%b", o_tip, e_tip); end
    end
    total++; if (o_tip !== 3'b010) begin bad++; $display("FAIL mtip_set got=%b exp=010", o_tip); end
    step64(0, 1, 1, 16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    total++; if (o_tip !== 3'b010) begin bad++; $display("FAIL mtip_lag got=%b exp=010", o_tip); end
    step64(0, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    total++; if (o_tip !== 3'b000) begin bad++; $display("FAIL mtip_clr got=%b exp=000", o_tip); end
  endtask

  task automatic test_back_to_back;
    step64(1, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    step64(0, 1, 1, 16'hBFF8, 64'd100, 8'hFF, 0);
    step64(0, 1, 0, 16'hBFF8, 64'h0, 8'h0, 0);
    total++; if (o_rv !== 1'b1 || o_rd !== 64'd100) begin bad++; $display("FAIL b2b_rd1 got=%b/%0d exp=1/100", o_rv, o_rd); end
    step64(0, 1, 1, 16'h4010, 64'd77, 8'hFF, 0);
    total++; if (o_rv !== 1'b1 || o_rd !== 64'd0) begin bad++; $display("FAIL b2b_wr got=%b/%h exp=1/0", o_rv, o_rd); end
    step64(0, 1, 0, 16'h4010, 64'h0, 8'h0, 0);
    total++; if (o_rv !== 1'b1 || o_rd !== 64'd77) begin bad++; $display("FAIL b2b_rd2 got=%b/%0d exp=1/77", o_rv, o_rd); end
  endtask

  task automatic test_random;
    logic [15:0] bases [9];
    logic [15:0] ad;
    logic [63:0] wd;
    logic [7:0]  ws;
    bit rs, v, we, te;
    bases = '{16'h0000, 16'h0008, 16'h4000, 16'h4008, 16'h4010,
              16'h4018, 16'hBFF8, 16'h8000, 16'h0010};
    step64(1, 0, 0, 16'h0, 64'h0, 8'h0, 0);
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      te = ($urandom_range(0, 3) != 0);
      ad = bases[$urandom_range(0, 8)] | 16'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ad = 16'($urandom);
      wd = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                       : 64'($urandom_range(0, 60));
      ws = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      step64(rs, v, we, ad, wd, ws, te);
      total++; if (o_rv !== e_rv || o_rd !== e_rd) begin bad++; $display("FAIL rnd_rsp i=%0d got=%b/%h exp=%b/%h", i, o_rv, o_rd, e_rv, e_rd); end
      total++; if (o_tip !== e_tip || o_sip !== e_sip) begin bad++; $display("FAIL rnd_irq i=%0d got=%b/%b exp=%b/%b", i, o_tip, o_sip, e_tip, e_sip); end
    end
  endtask

  task automatic test_x32_mtip;
    step32(1, 0, 0, 16'h0, 32'h0, 4'h0, 0);
    step32(0, 1, 1, 16'h4008, 32'h5, 4'hF, 0);
    step32(0, 1, 1, 16'h400C, 32'h0, 4'hF, 0);
    for (int i = 0; i < 5; i++) step32(0, 0, 0, 16'h0, 32'h0, 4'h0, 1);
    total++; if (q_tip !== 2'b00) begin bad++; $display("FAIL x32_tip_early got=%b exp=00", q_tip); end
    step32(0, 0, 0, 16'h0, 32'h0, 4'h0, 1);
    total++; if (q_tip !== 2'b10) begin bad++; $display("FAIL x32_tip_set got=%b exp=10", q_tip); end
    step32(0, 1, 1, 16'h400C, 32'hFFFF_FFFF, 4'hF, 1);
    total++; if (q_tip !== 2'b10) begin bad++; $display("FAIL x32_tip_lag got=%b exp=10", q_tip); end
    step32(0, 0, 0, 16'h0, 32'h0, 4'h0, 1);
    total++; if (q_tip !== 2'b00) begin bad++; $display("FAIL x32_tip_clr got=%b exp=00", q_tip); end
    step32(0, 1, 0, 16'h4008, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h5) begin bad++; $display("FAIL x32_cmp_lo got=%h exp=5", q_rd); end
    step32(0, 1, 0, 16'h400C, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL x32_cmp_hi got=%h exp=ffffffff", q_rd); end
  endtask

  task automatic test_x32_wrap;
    step32(1, 0, 0, 16'h0, 32'h0, 4'h0, 0);
    step32(0, 1, 1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0);
    step32(0, 1, 1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0);
    step32(0, 1, 0, 16'hBFFC, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL x32_max got=%h exp=ffffffff", q_rd); end
    step32(0, 0, 0, 16'h0, 32'h0, 4'h0, 1);
    step32(0, 1, 0, 16'hBFF8, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h0) begin bad++; $display("FAIL x32_wrap_lo got=%h exp=0", q_rd); end
    step32(0, 1, 0, 16'hBFFC, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h0) begin bad++; $display("FAIL x32_wrap_hi got=%h exp=0", q_rd); end
    step32(0, 1, 1, 16'hBFF8, 32'h10, 4'hF, 0);
    step32(0, 1, 1, 16'hBFFC, 32'hABCD, 4'hF, 1);
    step32(0, 1, 0, 16'hBFF8, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h10) begin bad++; $display("FAIL x32_tickwr_lo got=%h exp=10", q_rd); end
    step32(0, 1, 0, 16'hBFFC, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'hABCD) begin bad++; $display("FAIL x32_tickwr_hi got=%h exp=abcd", q_rd); end
    step32(0, 1, 1, 16'hBFF8, 32'h1234_5678, 4'hF, 1);
    step32(0, 1, 0, 16'hBFF8, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h1234_5678) begin bad++; $display("FAIL x32_tickwr_exact got=%h exp=12345678", q_rd); end
    step32(0, 1, 1, 16'hBFF8, 32'hAABB_CCDD, 4'b0010, 0);
    step32(0, 1, 0, 16'hBFF8, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h1234_CC78) begin bad++; $display("FAIL x32_strobe got=%h exp=1234cc78", q_rd); end
  endtask

  task automatic test_x32_msip;
    step32(1, 0, 0, 16'h0, 32'h0, 4'h0, 0);
    step32(0, 1, 1, 16'h0004, 32'h1, 4'h1, 0);
    total++; if (q_sip !== 2'b10) begin bad++; $display("FAIL x32_sip1 got=%b exp=10", q_sip); end
    step32(0, 1, 0, 16'h0004, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h1) begin bad++; $display("FAIL x32_sip_rd1 got=%h exp=1", q_rd); end
    step32(0, 1, 1, 16'h0008, 32'h1, 4'hF, 0);
    total++; if (q_sip !== 2'b10) begin bad++; $display("FAIL x32_sip_oor got=%b exp=10", q_sip); end
    step32(0, 1, 0, 16'h0008, 32'h0, 4'h0, 0);
    total++; if (q_rv !== 1'b1 || q_rd !== 32'h0) begin bad++; $display("FAIL x32_sip_rd_oor got=%b/%h exp=1/0", q_rv, q_rd); end
    step32(0, 1, 1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 0);
    total++; if (q_sip !== 2'b11) begin bad++; $display("FAIL x32_sip0 got=%b exp=11", q_sip); end
    step32(0, 1, 0, 16'h0000, 32'h0, 4'h0, 0);
    total++; if (q_rd !== 32'h1) begin bad++; $display("FAIL x32_sip_bit0 got=%h exp=1", q_rd); end
  endtask

  initial begin
    r64 = 1; v64 = 0; we64 = 0; ad64 = '0; wd64 = '0; ws64 = '0; te64 = 0;
    r32 = 1; v32 = 0; we32 = 0; ad32 = '0; wd32 = '0; ws32 = '0; te32 = 0;
    test_reset;
    test_prescale;
    test_strobe;
    test_msip;
    test_mtip;
    test_back_to_back;
    test_random;
    test_x32_mtip;
    test_x32_wrap;
    test_x32_msip;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
